// File: rtl/etherneco_synctimer_scheduler.sv
// EtherNeco sync-timer master sequencer: periodic sync frame builder and offset collector.
// Define ETHERNECO_SYNC_SCHED_MANUAL_EN to add the manual_trigger_i frame start input.
module etherneco_synctimer_scheduler #(
   parameter int unsigned TIMER_WIDTH  = 64,
   parameter int unsigned NODE_MAX     = 8,
   parameter int unsigned PERIOD_WIDTH = 32,
   parameter int unsigned TX_LATENCY   = 0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic [7:0]              node_count_i,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   input  logic [TIMER_WIDTH-1:0]  current_time_i,
`ifdef ETHERNECO_SYNC_SCHED_MANUAL_EN
   input  logic                    manual_trigger_i,
`endif
   output logic                    m_tx_first_o,
   output logic                    m_tx_last_o,
   output logic [7:0]              m_tx_data_o,
   output logic                    m_tx_valid_o,
   input  logic                    m_tx_ready_i,
   input  logic                    res_rx_start_i,
   input  logic                    res_rx_end_i,
   input  logic                    res_rx_error_i,
   input  logic [15:0]             s_res_pos_i,
   input  logic [7:0]              s_res_data_i,
   input  logic                    s_res_valid_i,
   output logic                    busy_o,
   output logic [31:0]             frame_count_o,
   output logic [15:0]             overrun_count_o
);

   localparam int unsigned KW = (NODE_MAX > 1) ? $clog2(NODE_MAX) : 1;
   localparam logic [PERIOD_WIDTH-1:0] PerOne = PERIOD_WIDTH'(1);

   typedef enum logic [2:0] {StIdle, StHead, StTime, StOffs, StLast} state_e;

   state_e                  state_q, nxt_state;
   logic [PERIOD_WIDTH-1:0] cnt_q, per_max;
   logic                    expire, trig, kick;
   logic [TIMER_WIDTH-1:0]  t_sum;
   logic [63:0]             t_next, t_q, t_shift;
   logic [7:0]              n_q, n_clamp, nxt_data;
   logic [15:0]             idx_q, nxt_idx, off_idx, last_idx;
   logic [2:0]              t_byte_sel;
   logic [31:0]             word, w_shift;
   logic                    tx_valid_q, tx_first_q, tx_last_q, busy_q;
   logic [7:0]              tx_data_q;
   logic [31:0]             frame_cnt_q;
   logic [15:0]             overrun_q;

   logic [31:0]             active_q [NODE_MAX];
   logic [31:0]             shadow_q [NODE_MAX];
   logic [31:0]             asm_q;
   logic                    err_q, pend_q, override_q;
   logic [15:0]             rpos;
   logic [13:0]             rk;
   logic                    res_hit;
   logic                    unused_bits;

`ifdef ETHERNECO_SYNC_SCHED_MANUAL_EN
   assign trig = manual_trigger_i;
`else
   assign trig = 1'b0;
`endif

   assign t_sum = current_time_i + TIMER_WIDTH'(TX_LATENCY);
   generate
      if (TIMER_WIDTH >= 64) begin : g_wide
         assign t_next = t_sum[63:0];
      end else begin : g_narrow
         assign t_next = {{(64 - TIMER_WIDTH){1'b0}}, t_sum};
      end
   endgenerate

   assign per_max  = (period_i == '0) ? PerOne : period_i;
   assign expire   = enable_i && (cnt_q >= per_max - PerOne);
   assign kick     = expire || trig;
   assign n_clamp  = (node_count_i > 8'(NODE_MAX)) ? 8'(NODE_MAX) : node_count_i;
   assign last_idx = 16'd8 + {6'd0, n_q, 2'b00};

   // Next byte of the frame: 1..8 are master time, then offset words, all little-endian.
   always_comb begin
      nxt_idx    = idx_q + 16'd1;
      off_idx    = nxt_idx - 16'd9;
      t_byte_sel = 3'(nxt_idx - 16'd1);
      t_shift    = t_q >> {t_byte_sel, 3'b000};
      word       = active_q[off_idx[KW+1:2]];
      w_shift    = word >> {off_idx[1:0], 3'b000};
      nxt_data   = (nxt_idx <= 16'd8) ? t_shift[7:0] : w_shift[7:0];
      if (nxt_idx == last_idx) begin
         nxt_state = StLast;
      end else if (nxt_idx <= 16'd8) begin
         nxt_state = StTime;
      end else begin
         nxt_state = StOffs;
      end
   end

   assign unused_bits = ^{off_idx[15:KW+2], t_shift[63:8], w_shift[31:8]};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         t_q         <= '0;
         n_q         <= '0;
         tx_valid_q  <= 1'b0;
         tx_first_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         tx_data_q   <= '0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
         overrun_q   <= '0;
      end else begin
         if (!enable_i || expire || (trig && state_q == StIdle)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + PerOne;
         end
         if (kick && state_q != StIdle && overrun_q != 16'hFFFF) begin
            overrun_q <= overrun_q + 16'd1;
         end
         case (state_q)
            StIdle: begin
               if (kick) begin
                  state_q    <= StHead;
                  t_q        <= t_next;
                  n_q        <= n_clamp;
                  idx_q      <= '0;
                  tx_valid_q <= 1'b1;
                  tx_first_q <= 1'b1;
                  tx_last_q  <= 1'b0;
                  tx_data_q  <= override_q ? 8'h03 : 8'h01;
                  busy_q     <= 1'b1;
               end
            end
            default: begin
               if (tx_valid_q && m_tx_ready_i) begin
                  if (tx_last_q) begin
                     state_q     <= StIdle;
                     tx_valid_q  <= 1'b0;
                     tx_first_q  <= 1'b0;
                     tx_last_q   <= 1'b0;
                     busy_q      <= 1'b0;
                     frame_cnt_q <= frame_cnt_q + 32'd1;
                  end else begin
                     state_q    <= nxt_state;
                     idx_q      <= nxt_idx;
                     tx_data_q  <= nxt_data;
                     tx_first_q <= 1'b0;
                     tx_last_q  <= (nxt_idx == last_idx);
                  end
               end
            end
         endcase
      end
   end

   assign rpos    = s_res_pos_i - 16'd9;
   assign rk      = rpos[15:2];
   assign res_hit = s_res_valid_i && (s_res_pos_i >= 16'd9) && ({2'b00, rk} < {8'd0, n_q});

   // Shadow collects this response; active only changes between frames.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         asm_q      <= '0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
         override_q <= 1'b1;
         for (int k = 0; k < NODE_MAX; k++) begin
            active_q[k] <= '0;
            shadow_q[k] <= '0;
         end
      end else begin
         if (res_rx_start_i) begin
            asm_q <= '0;
            err_q <= 1'b0;
         end else if (res_hit) begin
            for (int b = 0; b < 4; b++) begin
               if (rpos[1:0] == 2'(b)) asm_q[8*b +: 8] <= s_res_data_i;
            end
            if (rpos[1:0] == 2'd3) begin
               shadow_q[rk[KW-1:0]] <= {s_res_data_i, asm_q[23:0]} >> 1;
            end
         end
         if (res_rx_error_i) begin
            err_q      <= 1'b1;
            pend_q     <= 1'b0;
            override_q <= 1'b1;
            for (int k = 0; k < NODE_MAX; k++) shadow_q[k] <= active_q[k];
         end else if (res_rx_end_i && !err_q) begin
            override_q <= 1'b0;
            if (busy_q) begin
               pend_q <= 1'b1;
            end else begin
               for (int k = 0; k < NODE_MAX; k++) active_q[k] <= shadow_q[k];
            end
         end else if (pend_q && !busy_q) begin
            pend_q <= 1'b0;
            for (int k = 0; k < NODE_MAX; k++) active_q[k] <= shadow_q[k];
         end
      end
   end

   assign m_tx_first_o    = tx_first_q;
   assign m_tx_last_o     = tx_last_q;
   assign m_tx_data_o     = tx_data_q;
   assign m_tx_valid_o    = tx_valid_q;
   assign busy_o          = busy_q;
   assign frame_count_o   = frame_cnt_q;
   assign overrun_count_o = overrun_q;

endmodule
